keypad_debounce_encoder: RTL and testbench
==========================================

KEYPAD_DEBOUNCE_ENCODER -- requirements
Module: keypad_debounce_encoder

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a press or a release (legal range 2..255).
REQ-002 SHALL have port: clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: clearn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: keypad  input  10  raw asynchronous key lines, bit i high = digit key i pressed.
REQ-005 SHALL have port: digit  output  4  BCD value of last accepted key, 0..9.
REQ-006 SHALL have port: digit_valid  output  1  one-cycle strobe marking a newly accepted key; consumed by the oven time-entry logic.
REQ-007 SHALL have port: key_held  output  1  high while an accepted key is still considered pressed.
REQ-008 SHALL have port (only with KEYPAD_MULTIKEY_ERR_EN): multikey_err  output  1  one-cycle strobe on a multi-key condition in IDLE.

Function
REQ-009 SHALL pass keypad through a 2-flop synchronizer; all decisions use the second-stage value (sync).
REQ-010 SHALL implement states IDLE, DEBOUNCE, PRESSED, RELEASE, with an 8-bit stability counter cnt and a 10-bit candidate register.
REQ-011 IDLE: sync exactly one-hot -> DEBOUNCE, candidate=sync, cnt=1; sync zero or multi-hot -> stay IDLE.
REQ-012 DEBOUNCE: sync==candidate and cnt<DEBOUNCE_CYCLES -> cnt+1; sync==candidate and cnt==DEBOUNCE_CYCLES -> PRESSED; sync!=candidate -> IDLE, cnt=0.
REQ-013 On the DEBOUNCE->PRESSED edge SHALL load digit with the index of the candidate bit and assert digit_valid for exactly one cycle.
REQ-014 Latency: keypad stable before edge k -> digit_valid high for the cycle after edge k+2+DEBOUNCE_CYCLES, never earlier or later.
REQ-015 PRESSED: key_held=1; sync zero -> RELEASE, cnt=1; any nonzero sync (including additional keys) -> stay PRESSED, no new strobe.
REQ-016 RELEASE: key_held=1; sync zero and cnt<DEBOUNCE_CYCLES -> cnt+1; sync zero and cnt==DEBOUNCE_CYCLES -> IDLE, key_held=0; sync nonzero -> PRESSED.
REQ-017 A held key SHALL yield exactly one digit_valid regardless of hold time (no auto-repeat).
REQ-018 digit SHALL hold its value between strobes; it changes only on an accepted press.
REQ-019 cnt SHALL saturate and never wrap; unused state encodings SHALL return to IDLE next edge.

Reset
REQ-020 clearn low SHALL immediately force state=IDLE, cnt=0, candidate=0, synchronizer=0, digit=0, digit_valid=0, key_held=0, multikey_err=0.
REQ-021 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL discard the press; no strobe is emitted for it after release of reset.
REQ-022 After clearn deasserts, a key already held SHALL be treated as a fresh press (full debounce from IDLE).

Configuration
REQ-023 Macro KEYPAD_MULTIKEY_ERR_EN defined: multikey_err port present; pulses one cycle on each IDLE cycle where sync has two or more bits set.
REQ-024 Macro KEYPAD_MULTIKEY_ERR_EN undefined: port and logic absent; multi-hot input silently ignored; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Reset, then keypad=bit3 held 20 cycles from edge k -> single digit_valid after edge k+6, digit=3, key_held high until 4 zero samples after release.
REQ-026 keypad bit5 toggling every 2 cycles for 10 cycles then stable -> exactly one digit_valid, digit=5, no strobe during bounce.
REQ-027 keypad=bit1|bit2 held 20 cycles -> no digit_valid, digit unchanged; with macro, multikey_err pulses every IDLE cycle while multi-hot.
REQ-028 keypad=bit7 held 100 cycles, released 10 cycles, pressed again -> exactly two digit_valid pulses, both digit=7.
REQ-029 clearn pulsed low while in DEBOUNCE for bit9 -> outputs 0 immediately, no strobe; 1-cycle zero glitch during PRESSED -> no second strobe.

Source files
------------

// File: rtl/keypad_debounce_encoder.sv
// Keypad debouncer and BCD encoder for the oven time-entry panel.
// The ten raw key lines go through a 2-flop synchronizer. A single key must be
// seen stable for DEBOUNCE_CYCLES samples before it is accepted; it is then
// reported once as a BCD digit with a one-cycle strobe. A release must also be
// stable before the key is considered gone.
// Optional feature: define KEYPAD_MULTIKEY_ERR_EN to add a multikey_err strobe,
// which fires for idle samples that have two or more keys down.
module keypad_debounce_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [9:0] keypad,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       key_held
`ifdef KEYPAD_MULTIKEY_ERR_EN
    ,
    output logic       multikey_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

    logic [9:0] sync1_q, sync_q;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] cand_q, cand_d;
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    logic       mk_err_q, mk_err_d;
`endif

    logic       sync_nonzero, sync_onehot, sync_multi;
    logic [3:0] cand_idx;

    // Two-stage synchronizer for the asynchronous key lines
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= keypad;
            sync_q  <= sync1_q;
        end
    end

    // Classify the synchronized sample and encode the candidate key index
    always_comb begin
        sync_nonzero = (sync_q != 10'd0);
        sync_onehot  = sync_nonzero && ((sync_q & (sync_q - 10'd1)) == 10'd0);
        sync_multi   = sync_nonzero && !sync_onehot;
        cand_idx     = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (cand_q[i]) cand_idx = 4'(i);
        end
    end

    // Next-state logic for the debounce FSM; outputs are computed here and registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        digit_d  = digit_q;
        valid_d  = 1'b0;
        held_d   = held_q;
`ifdef KEYPAD_MULTIKEY_ERR_EN
        mk_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                held_d = 1'b0;
                if (sync_onehot) begin
                    state_d = ST_DEBOUNCE;
                    cand_d  = sync_q;
                    cnt_d   = 8'd1;
                end
`ifdef KEYPAD_MULTIKEY_ERR_EN
                mk_err_d = sync_multi;
`endif
            end
            ST_DEBOUNCE: begin
                if (sync_q == cand_q) begin
                    if (cnt_q >= CNT_MAX) begin
                        // Accepted: report once, then wait for release
                        state_d = ST_PRESSED;
                        digit_d = cand_idx;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        cnt_d   = 8'd0;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // Bounce or a different key: start over from idle
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            ST_PRESSED: begin
                held_d = 1'b1;
                if (!sync_nonzero) begin
                    state_d = ST_RELEASE;
                    cnt_d   = 8'd1;
                end
            end
            ST_RELEASE: begin
                held_d = 1'b1;
                if (sync_nonzero) begin
                    // Release glitch: still the same press, no new strobe
                    state_d = ST_PRESSED;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = ST_IDLE;
                    held_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                held_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            digit_q  <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
            mk_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
            mk_err_q <= mk_err_d;
`endif
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = valid_q;
    assign key_held     = held_q;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    assign multikey_err = mk_err_q;
`endif

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder with DEBOUNCE_CYCLES=4: directed scenarios
// followed by random key activity, compared every cycle against a model of
// the accept/release rules.
module tb_keypad_debounce_encoder;

    localparam int D = 4;

    logic       clock;
    logic       clearn;
    logic [9:0] keypad;
    logic [3:0] digit;
    logic       digit_valid;
    logic       key_held;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    logic       multikey_err;
`endif

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    keypad_debounce_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clock       (clock),
        .clearn      (clearn),
        .keypad      (keypad),
        .digit       (digit),
        .digit_valid (digit_valid),
        .key_held    (key_held)
`ifdef KEYPAD_MULTIKEY_ERR_EN
        ,
        .multikey_err(multikey_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: two-sample delay line, then the acceptance rules
    logic [9:0] m_s1, m_s2, m_cand;
    int         m_run, m_zeros;
    bit         m_pressed, m_valid, m_err;
    logic [3:0] m_digit;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cand = '0;
        m_run = 0; m_zeros = 0;
        m_pressed = 0; m_valid = 0; m_err = 0;
        m_digit = '0;
    endtask

    task automatic model_edge(input logic [9:0] kp);
        logic [9:0] s;
        s = m_s2;
        m_valid = 0;
        m_err = 0;
        if (!m_pressed) begin
            if (m_run == 0) begin
                if ($countones(s) == 1) begin
                    m_cand = s;
                    m_run = 1;
                end else if ($countones(s) >= 2) begin
                    m_err = 1;
                end
            end else if (s == m_cand) begin
                if (m_run >= D) begin
                    m_pressed = 1;
                    m_zeros = 0;
                    m_run = 0;
                    m_valid = 1;
                    for (int i = 0; i < 10; i++) if (s[i]) m_digit = 4'(i);
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (s != 0) m_zeros = 0;
            else if (m_zeros >= D) begin
                m_pressed = 0;
                m_zeros = 0;
            end else m_zeros++;
        end
        m_s2 = m_s1;
        m_s1 = kp;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("digit", 32'(digit), 32'(m_digit));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("key_held", 32'(key_held), 32'(m_pressed));
`ifdef KEYPAD_MULTIKEY_ERR_EN
        chk("multikey_err", 32'(multikey_err), 32'(m_err));
`endif
    endtask

    // One clock: drive keypad, advance the model at the edge, check at the falling edge
    task automatic cyc(input logic [9:0] kp);
        keypad = kp;
        @(posedge clock);
        model_edge(kp);
        @(negedge clock);
        check_outputs();
        if (digit_valid === 1'b1) vcount++;
    endtask

    task automatic check_zero_outputs();
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
`ifdef KEYPAD_MULTIKEY_ERR_EN
        chk("rst_mkerr", 32'(multikey_err), 32'd0);
`endif
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear at once
    task automatic do_reset(input logic [9:0] kp);
        keypad = kp;
        clearn = 1'b0;
        #1;
        check_zero_outputs();
        model_reset();
        @(negedge clock);
        clearn = 1'b1;
    endtask

    initial begin
        int v0;
        int kind, len, k2;
        logic [9:0] kv, kv2;
        logic [3:0] dsave;

        keypad = '0;
        clearn = 1'b0;
        model_reset();
        #3;
        check_zero_outputs();
        repeat (2) @(negedge clock);
        clearn = 1'b1;
        repeat (3) cyc(10'd0);

        // Bit 3 held 20 cycles: single strobe exactly 6 edges after the first sample
        v0 = vcount;
        for (int i = 0; i < 20; i++) begin
            cyc(10'b00_0000_1000);
            chk("lat_valid", 32'(digit_valid), 32'(i == 6));
        end
        chk("b3_count", 32'(vcount - v0), 32'd1);
        chk("b3_digit", 32'(digit), 32'd3);
        for (int i = 0; i < 10; i++) begin
            cyc(10'd0);
            chk("rel_held", 32'(key_held), 32'(i < 6));
        end

        // Bit 5 bouncing every 2 cycles, then stable
        v0 = vcount;
        for (int i = 0; i < 10; i++) cyc(((i / 2) % 2 == 0) ? 10'b00_0010_0000 : 10'd0);
        chk("bounce_nostrobe", 32'(vcount - v0), 32'd0);
        repeat (20) cyc(10'b00_0010_0000);
        chk("bounce_count", 32'(vcount - v0), 32'd1);
        chk("bounce_digit", 32'(digit), 32'd5);
        repeat (12) cyc(10'd0);

        // Two keys at once are ignored
        v0 = vcount;
        dsave = digit;
        repeat (20) cyc(10'b00_0000_0110);
        chk("multi_count", 32'(vcount - v0), 32'd0);
        chk("multi_digit", 32'(digit), 32'(dsave));
        repeat (5) cyc(10'd0);

        // Bit 7 long hold, release, press again: two strobes, no auto-repeat
        v0 = vcount;
        repeat (100) cyc(10'b00_1000_0000);
        chk("hold_count", 32'(vcount - v0), 32'd1);
        repeat (10) cyc(10'd0);
        repeat (20) cyc(10'b00_1000_0000);
        chk("repress_count", 32'(vcount - v0), 32'd2);
        chk("repress_digit", 32'(digit), 32'd7);
        repeat (12) cyc(10'd0);

        // Reset during debounce of bit 9 discards the press
        v0 = vcount;
        repeat (4) cyc(10'b10_0000_0000);
        do_reset(10'd0);
        repeat (12) cyc(10'd0);
        chk("rst_discard", 32'(vcount - v0), 32'd0);

        // Reset while bit 9 is accepted and still held: fresh full debounce
        repeat (10) cyc(10'b10_0000_0000);
        do_reset(10'b10_0000_0000);
        v0 = vcount;
        for (int i = 0; i < 12; i++) begin
            cyc(10'b10_0000_0000);
            chk("fresh_valid", 32'(digit_valid), 32'(i == 6));
        end
        // One-cycle drop while pressed: no second strobe
        cyc(10'd0);
        repeat (10) cyc(10'b10_0000_0000);
        chk("glitch_count", 32'(vcount - v0), 32'd1);
        chk("glitch_held", 32'(key_held), 32'd1);
        repeat (12) cyc(10'd0);

        // Random key activity checked against the model
        for (int seg = 0; seg < 150; seg++) begin
            kind = int'($urandom_range(0, 9));
            kv = 10'd1 << $urandom_range(0, 9);
            len = int'($urandom_range(1, 30));
            if (kind < 4) begin
                repeat (len) cyc(kv);
                repeat ($urandom_range(1, 12)) cyc(10'd0);
            end else if (kind < 6) begin
                for (int i = 0; i < len; i++) cyc(($urandom_range(0, 2) != 0) ? kv : 10'd0);
            end else if (kind < 8) begin
                k2 = int'($urandom_range(0, 9));
                kv2 = kv | (10'd1 << k2);
                repeat (len) cyc(kv2);
            end else if (kind == 8) begin
                repeat (len) cyc(10'($urandom_range(0, 1023)));
            end else begin
                if ($urandom_range(0, 3) == 0) do_reset(kv);
                else repeat (len) cyc(10'd0);
            end
        end
        repeat (15) cyc(10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
